usb_fs_tx_line: RTL and testbench
=================================

Name: usb_fs_tx_line

Overview:
- Full-speed USB line transmitter. Takes packet bytes over a valid/ready byte stream and drives the differential dp/dn pair plus its output enable.
- Generates SYNC, LSB-first serialisation, bit stuffing, NRZI encoding and EOP.
- Sits directly upstream of the bus-side packet decoder and monitor. Its dp/dn outputs are what they sample and decode.

Parameters:
- CLK_PER_BIT, 4, clock cycles per USB bit period (4 gives 12 Mbit/s from a 48 MHz clk_i); legal range 2..16.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; synchronous, active-high.
- tx_data_i  input  8  packet byte; the first byte of a packet is the PID.
- tx_valid_i  input  1  tx_data_i/tx_last_i are valid.
- tx_last_i  input  1  qualifies the final byte of the packet.
- tx_ready_o  output  1  block accepts a byte this cycle; a transfer occurs on valid&&ready.
- dp_tx_o  output  1  D+ drive value.
- dn_tx_o  output  1  D- drive value.
- tx_oe_o  output  1  line driver enable; high from the first SYNC bit to the end of EOP.
- busy_o  output  1  a packet is in flight (state != IDLE).
- underrun_o  output  1  one-cycle pulse when the packet is aborted for lack of data.

Behaviour:
- Line states:
  - J = dp1/dn0.
  - K = dp0/dn1.
  - SE0 = dp0/dn0.
- Reset values:
  - dp_tx_o=1, dn_tx_o=0 (J).
  - tx_oe_o=0, busy_o=0, underrun_o=0.
  - Holding register empty, so tx_ready_o=1 from the first cycle after reset.
- Buffering:
  - One holding register (byte plus last flag) feeds one shift register.
  - tx_ready_o = !hold_full. This is combinational from state only, never from tx_valid_i.
  - Hold moves to shift at the start of the first bit period of each byte; hold is free again that cycle.
- Bit timer:
  - Counter 0..CLK_PER_BIT-1, cleared on packet start.
  - A bit boundary occurs when the counter wraps. dp/dn change only at boundaries, and each line state holds exactly CLK_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: on the cycle after a transfer, go to SYNC. The first SYNC bit (K) and tx_oe_o=1 appear in that same cycle, so accept-to-line latency is 1 clock.
  - SYNC: 8 bits 00000001 (LSB first), giving K J K J K J K K. Then go to DATA, loading hold to shift.
  - DATA: send the 8 bits LSB first.
    - After each bit, if the ones counter reaches 6, go to STUFF.
    - At the end of a byte with last set, go to EOP_SE0.
    - At the end of a byte with hold full, load hold and continue.
    - At the end of a byte with hold empty and last not yet sent, pulse underrun_o and go to EOP_SE0.
  - STUFF: one inserted 0 bit, then return to DATA (or EOP_SE0 if the stuffed bit followed the final data bit).
  - EOP_SE0: SE0 for 2 bit periods, then EOP_J.
  - EOP_J: J for 1 bit period. Then tx_oe_o=0, go to IDLE, busy_o=0.
- NRZI encoding:
  - Bit 0 toggles J/K; bit 1 holds.
  - The encoder's previous state is J at packet start.
- Stuffing rules:
  - The ones counter is cleared at packet start and counts consecutive 1s, including the final SYNC 1.
  - A 0 data bit or a stuff bit clears the counter.
  - Stuffing applies even if the sixth 1 is the last data bit.
- Handshake during a packet:
  - tx_ready_o may be high while busy. A byte accepted during EOP is held and starts a new packet after the return to IDLE.
  - There is no inter-packet gap beyond that IDLE cycle.
- Underrun: the partial packet ends with a normal EOP. The caller is responsible for the resulting CRC error at the receiver.
- Reset mid-packet: outputs return to reset values on the next clock. The holding register and shift register are discarded.
- tx_last_i is ignored unless tx_valid_i is high.

Decomposition:
- Shared package usb_pkg:
  - Line-state constants J/K/SE0.
  - PID constants (OUT, IN, SOF, SETUP, DATA0/1, ACK, NAK, STALL) as 4-bit values.
  - SYNC pattern constant 8'h80 (LSB-first 00000001).
  - FSM state enum.
- One sub-module: usb_tx_nrzi_stuff. It takes a serial bit, a bit strobe and a force-SE0 input, and produces the stuff request and the encoded dp/dn. The FSM, hold/shift registers and handshake stay in the top module.

Test Plan:
- ACK packet: single byte 0xD2 with last, CLK_PER_BIT=4 -> line shows K J K J K J K K, J J K J J K K K, SE0 SE0 J, each state 4 cycles. tx_oe_o is high for exactly 76 cycles, and no underrun occurs.
- Stuffing: bytes 0xFF, 0xFF(last) -> stuff 0 inserted after the 5th and 11th data 1s. 26 bit periods precede EOP, and no 7 consecutive identical J/K states appear.
- Back-to-back: a DATA0 packet (0xC3 plus 8 bytes) with tx_valid_i held high -> no underrun, and tx_ready_o is low only while hold is full. A second packet queued during EOP starts SYNC 1 cycle after EOP_J ends.
- Underrun: PID 0x4B plus one byte, then tx_valid_i drops without last -> underrun_o pulses once after the second byte, followed by SE0 SE0 J and tx_oe_o=0.
- Reset mid-packet: rst_i asserted during DATA byte 3 -> next cycle dp=1/dn=0, tx_oe_o=0, busy_o=0, tx_ready_o=1. A new 0xD2 packet afterwards is line-correct.
- CLK_PER_BIT=2 rerun of the ACK case -> identical line sequence, each state held 2 cycles.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and types for the full-speed USB line transmitter.
package usb_pkg;

  // Line states as {dp, dn}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Sent LSB first: seven 0s then a 1
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/usb_fs_tx_line_if.sv
// Byte-stream handshake between a packet source and the USB line transmitter.
interface usb_fs_tx_line_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_last_i;
  logic       tx_ready_o;

  modport master (output tx_data_i, output tx_valid_i, output tx_last_i, input tx_ready_o);
  modport slave  (input tx_data_i, input tx_valid_i, input tx_last_i, output tx_ready_o);
endinterface

// File: rtl/usb_tx_nrzi_stuff.sv
// NRZI encoder with consecutive-ones tracking; line outputs change only on bit strobes.
module usb_tx_nrzi_stuff
  import usb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic bit_strobe_i,
  input  logic bit_i,
  input  logic force_se0_i,
  output logic stuff_req_o,
  output logic dp_o,
  output logic dn_o
);

  logic       level_j;
  logic [2:0] ones;

  assign stuff_req_o = (ones == 3'd6);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_j      <= 1'b1;
      ones         <= '0;
      {dp_o, dn_o} <= LINE_J;
    end else if (bit_strobe_i) begin
      if (force_se0_i) begin
        // EOP leaves the encoder parked on J, ready for the next SYNC
        level_j      <= 1'b1;
        ones         <= '0;
        {dp_o, dn_o} <= LINE_SE0;
      end else if (bit_i) begin
        if (ones != 3'd7) ones <= ones + 3'd1;
        {dp_o, dn_o} <= level_j ? LINE_J : LINE_K;
      end else begin
        level_j      <= !level_j;
        ones         <= '0;
        {dp_o, dn_o} <= level_j ? LINE_K : LINE_J;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx_line.sv
// Full-speed USB line transmitter: SYNC, LSB-first bytes, bit stuffing, NRZI, EOP.
module usb_fs_tx_line
  import usb_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 4
)
(
  input  logic            clk_i,
  input  logic            rst_i,
  usb_fs_tx_line_if.slave tx,
  output logic            dp_tx_o,
  output logic            dn_tx_o,
  output logic            tx_oe_o,
  output logic            busy_o,
  output logic            underrun_o
);

  localparam logic [3:0] CNT_MAX = 4'(CLK_PER_BIT - 1);

  tx_state_t  state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_q, hold_q;
  logic       shift_last, hold_last, hold_full;
  logic       bit_end, pkt_start, pkt_end;
  logic       bit_strobe, bit_val, force_se0, stuff_req;
  logic       load_hold, shift_adv, underrun_nxt;

  assign bit_end       = (state != ST_IDLE) && (cnt == CNT_MAX);
  assign pkt_start     = (state == ST_IDLE) && hold_full;
  assign pkt_end       = (state == ST_EOP_J) && bit_end;
  assign busy_o        = (state != ST_IDLE);
  assign tx.tx_ready_o = !hold_full;

  // Decides, at each bit boundary, the next state and the bit that starts now
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    bit_strobe   = 1'b0;
    bit_val      = 1'b0;
    force_se0    = 1'b0;
    load_hold    = 1'b0;
    shift_adv    = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_nxt   = ST_SYNC;
          bit_cnt_nxt = '0;
          bit_strobe  = 1'b1;
          bit_val     = SYNC_PATTERN[0];
        end
      end
      ST_SYNC: begin
        if (bit_end) begin
          bit_strobe = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            load_hold   = 1'b1;
            bit_val     = hold_q[0];
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            bit_val     = SYNC_PATTERN[bit_cnt_nxt];
          end
        end
      end
      ST_DATA, ST_STUFF: begin
        if (bit_end) begin
          bit_strobe = 1'b1;
          // A stuff bit after the last data bit still completes before byte-end handling
          if (state == ST_DATA && stuff_req) begin
            state_nxt = ST_STUFF;
            bit_val   = 1'b0;
          end else if (bit_cnt != 3'd7) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = bit_cnt + 3'd1;
            shift_adv   = 1'b1;
            bit_val     = shift_q[1];
          end else if (!shift_last && hold_full) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            load_hold   = 1'b1;
            bit_val     = hold_q[0];
          end else begin
            state_nxt    = ST_EOP_SE0;
            bit_cnt_nxt  = '0;
            force_se0    = 1'b1;
            underrun_nxt = !shift_last;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_end) begin
          bit_strobe = 1'b1;
          if (bit_cnt == 3'd1) begin
            state_nxt = ST_EOP_J;
            bit_val   = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            force_se0   = 1'b1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      shift_last <= 1'b0;
      hold_q     <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      tx_oe_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      underrun_o <= underrun_nxt;

      if (state == ST_IDLE || bit_end) cnt <= '0;
      else                             cnt <= cnt + 4'd1;

      if (pkt_start)    tx_oe_o <= 1'b1;
      else if (pkt_end) tx_oe_o <= 1'b0;

      if (load_hold) begin
        shift_q    <= hold_q;
        shift_last <= hold_last;
      end else if (shift_adv) begin
        shift_q <= {1'b0, shift_q[7:1]};
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end else if (tx.tx_valid_i && !hold_full) begin
        hold_q    <= tx.tx_data_i;
        hold_last <= tx.tx_last_i;
        hold_full <= 1'b1;
      end
    end
  end

  usb_tx_nrzi_stuff u_nrzi (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bit_strobe_i(bit_strobe),
    .bit_i       (bit_val),
    .force_se0_i (force_se0),
    .stuff_req_o (stuff_req),
    .dp_o        (dp_tx_o),
    .dn_o        (dn_tx_o)
  );

endmodule

// File: tb/tb_usb_fs_tx_line.sv
// Directed bench for usb_fs_tx_line: two instances (4 and 2 clocks per bit) share one stimulus.
module tb_usb_fs_tx_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, tv, tl;
  logic [7:0] td;
  logic [7:0] pkt [16];
  int         checks = 0;
  int         errors = 0;

  usb_fs_tx_line_if if4 ();
  usb_fs_tx_line_if if2 ();

  assign if4.tx_valid_i = tv && !sel;
  assign if4.tx_data_i  = td;
  assign if4.tx_last_i  = tl;
  assign if2.tx_valid_i = tv && sel;
  assign if2.tx_data_i  = td;
  assign if2.tx_last_i  = tl;

  logic dp4, dn4, oe4, busy4, und4;
  logic dp2, dn2, oe2, busy2, und2;

  usb_fs_tx_line #(.CLK_PER_BIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .tx(if4), .dp_tx_o(dp4), .dn_tx_o(dn4),
    .tx_oe_o(oe4), .busy_o(busy4), .underrun_o(und4));

  usb_fs_tx_line #(.CLK_PER_BIT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .tx(if2), .dp_tx_o(dp2), .dn_tx_o(dn2),
    .tx_oe_o(oe2), .busy_o(busy2), .underrun_o(und2));

  logic obs_dp, obs_dn, obs_oe, obs_busy, obs_under, obs_ready;
  assign obs_dp    = sel ? dp2   : dp4;
  assign obs_dn    = sel ? dn2   : dn4;
  assign obs_oe    = sel ? oe2   : oe4;
  assign obs_busy  = sel ? busy2 : busy4;
  assign obs_under = sel ? und2  : und4;
  assign obs_ready = sel ? if2.tx_ready_o : if4.tx_ready_o;

  function automatic byte line_chr(input logic dp, input logic dn);
    if (dp === 1'b1 && dn === 1'b0) return "J";
    if (dp === 1'b0 && dn === 1'b1) return "K";
    if (dp === 1'b0 && dn === 1'b0) return "0";
    return "?";
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Feeds pkt[0..nbytes-1] as the DUT accepts them and checks every line cycle
  // against exp (one character per bit period).
  task automatic run_case(input string tag, input int unsigned cpb, input string exp,
                          input int unsigned nbytes, input bit with_last, input bit queue_next,
                          input int unsigned exp_wait, input int unsigned exp_under,
                          input int unsigned abort_at);
    int unsigned idx = 0, cyc = 0, waitc = 0, under = 0;
    bit started = 0, done = 0, xfer = 0, just_xfer = 0;
    @(posedge clk); #1;
    if (nbytes > 0) begin
      td = pkt[0];
      tl = with_last && (nbytes == 1);
      tv = 1'b1;
    end
    for (int g = 0; g < 4000 && !done; g++) begin
      @(negedge clk);
      if (just_xfer) chk({tag, "_ready_after_accept"}, 32'(obs_ready), 32'd0);
      xfer = tv && obs_ready;
      if (obs_oe) begin
        started = 1;
        if (cyc / cpb < exp.len())
          chk({tag, "_line"}, 32'(line_chr(obs_dp, obs_dn)), 32'(exp[cyc / cpb]));
        else
          chk({tag, "_oe_too_long"}, 32'(obs_oe), 32'd0);
        cyc++;
        if (abort_at != 0 && cyc == abort_at) done = 1;
      end else if (started) begin
        done = 1;
      end else begin
        waitc++;
      end
      if (obs_under) under++;
      if (!done) begin
        @(posedge clk); #1;
        just_xfer = xfer;
        if (xfer) begin
          idx++;
          if (idx < nbytes) begin
            td = pkt[idx];
            tl = with_last && (idx == nbytes - 1);
          end else begin
            tv = 1'b0;
          end
        end
        if (queue_next && idx == nbytes && !tv && cyc >= (exp.len() - 3) * cpb) begin
          td = 8'hD2;
          tl = 1'b1;
          tv = 1'b1;
        end
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    if (abort_at != 0) return;
    chk({tag, "_oe_cycles"}, cyc, exp.len() * cpb);
    chk({tag, "_underruns"}, under, exp_under);
    chk({tag, "_start_wait"}, waitc, exp_wait);
    chk({tag, "_idle_line"}, 32'(line_chr(obs_dp, obs_dn)), 32'("J"));
    chk({tag, "_idle_busy"}, 32'(obs_busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dp"}, 32'(obs_dp), 32'd1);
    chk({tag, "_dn"}, 32'(obs_dn), 32'd0);
    chk({tag, "_oe"}, 32'(obs_oe), 32'd0);
    chk({tag, "_busy"}, 32'(obs_busy), 32'd0);
    chk({tag, "_underrun"}, 32'(obs_under), 32'd0);
    chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
  endtask

  string exp_ack, exp_stuff, exp_und, exp_d0;

  initial begin
    rst = 1'b1; sel = 1'b0; tv = 1'b0; tl = 1'b0; td = '0;
    exp_ack   = {"KJKJKJKK", "JJKJJKKK", "00J"};
    exp_stuff = {"KJKJKJKK", "KKKKKJ", "JJJJJJK", "KKKKK", "00J"};
    exp_und   = {"KJKJKJKK", "KKJJKJJK", "JKJKJKJK", "00J"};
    exp_d0    = {"KJKJKJKK", "KKJKJKKK"};
    for (int i = 0; i < 8; i++) exp_d0 = {exp_d0, "JKJKJKJK"};
    exp_d0 = {exp_d0, "00J"};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst4");
    sel = 1'b1; #1;
    chk_reset_state("rst2");
    sel = 1'b0; #1;

    // last without valid must not start anything
    tl = 1'b1;
    repeat (3) @(negedge clk);
    chk("last_no_valid_busy", 32'(obs_busy), 32'd0);
    chk("last_no_valid_oe", 32'(obs_oe), 32'd0);
    tl = 1'b0;

    pkt[0] = 8'hD2;
    run_case("ack4", 4, exp_ack, 1, 1'b1, 1'b0, 2, 0, 0);

    pkt[0] = 8'hFF; pkt[1] = 8'hFF;
    run_case("stuff", 4, exp_stuff, 2, 1'b1, 1'b0, 2, 0, 0);

    pkt[0] = 8'hC3;
    for (int i = 1; i <= 8; i++) pkt[i] = 8'h00;
    run_case("data0", 4, exp_d0, 9, 1'b1, 1'b1, 2, 0, 0);
    run_case("queued_ack", 4, exp_ack, 0, 1'b1, 1'b0, 0, 0, 0);

    pkt[0] = 8'h4B; pkt[1] = 8'h00;
    run_case("underrun", 4, exp_und, 2, 1'b0, 1'b0, 2, 1, 0);

    pkt[0] = 8'hC3;
    for (int i = 1; i <= 4; i++) pkt[i] = 8'h00;
    run_case("abort", 4, exp_d0, 5, 1'b1, 1'b0, 2, 0, (8 + 8 + 8 + 8 + 2) * 4);
    rst = 1'b1;
    tv  = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;

    pkt[0] = 8'hD2;
    run_case("ack_after_rst", 4, exp_ack, 1, 1'b1, 1'b0, 2, 0, 0);

    sel = 1'b1;
    run_case("ack2", 2, exp_ack, 1, 1'b1, 1'b0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
